// File: rtl/replay_pkg.sv
// Shared types and constants for the replay link scheduler.
// Contents: FSM state encoding, sequence/source-id widths, header builder.
// Imported by replay_link_scheduler.
package replay_pkg;

  localparam int SEQ_W    = 7;
  localparam int SRC_ID_W = 1;
  localparam logic [SEQ_W-1:0] SEQ_MAX = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Header byte sent ahead of every frame: {source id, sequence number}.
  function automatic logic [7:0] make_hdr(input logic [SRC_ID_W-1:0] id,
                                          input logic [SEQ_W-1:0]    seq);
    return {id, seq};
  endfunction

endpackage

// File: rtl/replay_link_scheduler_rr_arbiter2.sv
// Two-way round-robin pick between frame requesters.
// Latency: combinational; the round-robin pointer lives in the parent.
// Backpressure: none; the parent only samples the result while idle.
// Ports: eligible[1:0] in, last_winner in (source id of previous owner),
//        winner[1:0] out (one-hot), any out (at least one eligible).
module rr_arbiter2 (
  input  logic [1:0] eligible,
  input  logic       last_winner,
  output logic [1:0] winner,
  output logic       any
);

  // On contention the source that did not win last time goes next;
  // a lone eligible source always wins regardless of the pointer.
  always_comb begin
    winner[0] = eligible[0] & (~eligible[1] |  last_winner);
    winner[1] = eligible[1] & (~eligible[0] | ~last_winner);
  end

  assign any = |eligible;

endmodule

// File: rtl/replay_link_scheduler.sv
// Frame scheduler for two byte sources sharing one replay-protected link.
// Latency: grant 1 cycle after request; header then FRAME_LEN payload bytes.
// Backpressure: link_ready stalls header and payload; src_ready mirrors it.
// Ports: clk, reset (sync, active-high), enable, req[1:0], srcN_data/valid,
//        grant[1:0], src_ready[1:0], link_data/valid/ready, frame_end,
//        seq_lock[1:0], frame_abort.
// Build option REPLAY_TIMEOUT_EN: abort a frame after TIMEOUT_CYC cycles of
// source silence in PAYLOAD; otherwise PAYLOAD waits forever.
module replay_link_scheduler
  import replay_pkg::*;
#(
  parameter int FRAME_LEN = 4
`ifdef REPLAY_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req,
  input  logic [7:0] src0_data,
  input  logic       src0_valid,
  input  logic [7:0] src1_data,
  input  logic       src1_valid,
  output logic [1:0] grant,
  output logic [1:0] src_ready,
  output logic [7:0] link_data,
  output logic       link_valid,
  input  logic       link_ready,
  output logic       frame_end,
  output logic [1:0] seq_lock,
  output logic       frame_abort
);

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_t           state;
  logic [SEQ_W-1:0] seq0, seq1;
  logic             last_winner;
  logic [7:0]       cnt;

  logic [1:0]       win;
  logic             win_any;
  logic             cur_id;
  logic             cur_valid;
  logic [7:0]       cur_data;
  logic [SEQ_W-1:0] cur_seq;
  logic             pay_hs;
  logic             timeout_hit;

  rr_arbiter2 u_arb (
    .eligible    (req & ~seq_lock),
    .last_winner (last_winner),
    .winner      (win),
    .any         (win_any)
  );

  assign cur_id    = grant[1];
  assign cur_valid = cur_id ? src1_valid : src0_valid;
  assign cur_data  = cur_id ? src1_data  : src0_data;
  assign cur_seq   = cur_id ? seq1       : seq0;
  assign pay_hs    = (state == ST_PAYLOAD) && cur_valid && link_ready;

  // Link side is driven combinationally from registered state so the header
  // stays stable under backpressure and payload bytes cut straight through.
  always_comb begin
    link_valid = 1'b0;
    link_data  = 8'h00;
    src_ready  = 2'b00;
    frame_end  = 1'b0;
    case (state)
      ST_HDR: begin
        link_valid = 1'b1;
        link_data  = make_hdr(cur_id, cur_seq);
      end
      ST_PAYLOAD: begin
        link_valid = cur_valid;
        link_data  = cur_data;
        src_ready  = grant & {2{link_ready}};
        frame_end  = pay_hs && (cnt == LAST_IDX);
      end
      default: ;
    endcase
  end

`ifdef REPLAY_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_cnt;

  // Only cycles where the source itself is silent count as a stall; a link
  // backpressure cycle with valid data holds the count.
  assign timeout_hit = (state == ST_PAYLOAD) && !cur_valid &&
                       (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset || state != ST_PAYLOAD || pay_hs) begin
      stall_cnt <= '0;
    end else if (!cur_valid) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign frame_abort = timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant       <= 2'b00;
      seq0        <= '0;
      seq1        <= '0;
      last_winner <= 1'b1;
      cnt         <= 8'h00;
      seq_lock    <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && win_any) begin
            grant <= win;
            state <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (link_ready) begin
            cnt   <= 8'h00;
            state <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (pay_hs) begin
            cnt <= cnt + 8'h01;
            if (cnt == LAST_IDX) state <= ST_DONE;
          end else if (timeout_hit) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The last sequence number locks the source instead of wrapping,
          // so a number is never reused before reset.
          if (cur_id) begin
            if (seq1 == SEQ_MAX) seq_lock[1] <= 1'b1;
            else                 seq1 <= seq1 + 1'b1;
          end else begin
            if (seq0 == SEQ_MAX) seq_lock[0] <= 1'b1;
            else                 seq0 <= seq0 + 1'b1;
          end
          last_winner <= cur_id;
          grant       <= 2'b00;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
